// File: rtl/inst_fifo_arb.sv
// Round-robin write arbiter sharing one instruction FIFO between NREQ producers.
// Grants one producer at a time; releases on packet end or burst cap.
module inst_fifo_arb #(
    parameter int DWIDTH    = 16,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DWIDTH-1:0]   req_data,
    input  logic [NREQ-1:0]          req_last,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     fifo_full,
    output logic                     fifo_wr_en,
    output logic [DWIDTH-1:0]        fifo_din,
    output logic [NREQ-1:0]          grant,
    output logic                     busy
);

    localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [LW-1:0]     last_q, last_d;
    logic [BW-1:0]     beats_q, beats_d;
    logic [LW-1:0]     owner;
    logic [LW-1:0]     arb_ptr;
    logic [LW-1:0]     pick;
    logic              pick_ok;
    logic              beat;
    logic              rel;

    always_comb begin
        owner = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) owner = LW'(i);
        end
    end

    // On release the old owner becomes the pointer, so it gets lowest priority.
    assign arb_ptr = (state_q == GRANT) ? owner : last_q;

    always_comb begin
        pick    = '0;
        pick_ok = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req_valid[(int'(arb_ptr) + k) % NREQ]) begin
                pick    = LW'((int'(arb_ptr) + k) % NREQ);
                pick_ok = 1'b1;
            end
        end
    end

    assign busy       = (state_q == GRANT);
    assign grant      = grant_q;
    assign req_ready  = (busy && !fifo_full) ? grant_q : '0;
    assign beat       = busy & req_valid[owner] & ~fifo_full;
    assign fifo_wr_en = beat;
    assign fifo_din   = beat ? req_data[int'(owner)*DWIDTH +: DWIDTH] : '0;
    assign rel        = beat & (req_last[owner] |
                                (beats_q + BW'(1) == BW'(MAX_BURST)));

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        beats_d = beats_q;
        unique case (state_q)
            IDLE: begin
                if (pick_ok) begin
                    state_d = GRANT;
                    grant_d = NREQ'(1) << pick;
                end
            end
            GRANT: begin
                if (rel) begin
                    last_d  = owner;
                    beats_d = '0;
                    if (pick_ok) begin
                        grant_d = NREQ'(1) << pick;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end else if (beat) begin
                    beats_d = beats_q + BW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= LW'(NREQ - 1);
            beats_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            beats_q <= beats_d;
        end
    end

endmodule
